// File: rtl/input_queues.sv
// Bank of independent circular FIFOs, one per scheduler input.
// Head words are presented combinationally from registered state; overflow/underflow are sticky.
module input_queues #(
    parameter int DATA_WIDTH = 16,
    parameter int N_INPUTS   = 4,
    parameter int DEPTH      = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [N_INPUTS-1:0]            push,
    input  logic [DATA_WIDTH*N_INPUTS-1:0] d_in,
    input  logic [N_INPUTS-1:0]            pop,
    output logic [DATA_WIDTH*N_INPUTS-1:0] q_out,
    output logic [N_INPUTS-1:0]            empty,
    output logic [N_INPUTS-1:0]            full,
    output logic [N_INPUTS-1:0]            overflow,
    output logic [N_INPUTS-1:0]            underflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    for (genvar g = 0; g < N_INPUTS; g++) begin : g_q
        logic [DATA_WIDTH-1:0] mem [DEPTH];
        logic [PW-1:0]         wptr;
        logic [PW-1:0]         rptr;
        logic [CW-1:0]         cnt;
        logic                  is_empty;
        logic                  is_full;
        logic                  do_push;
        logic                  do_pop;
        logic                  ovf;
        logic                  unf;

        assign is_empty = (cnt == '0);
        assign is_full  = (cnt == CW'(DEPTH));
        // A pop on a full queue frees the slot the push needs; a pop on an empty queue never sees the push.
        assign do_push  = push[g] && (!is_full || pop[g]);
        assign do_pop   = pop[g] && !is_empty;

        // DEPTH is a power of two, so natural pointer rollover is the modulo-DEPTH wrap.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                wptr <= '0;
                rptr <= '0;
                cnt  <= '0;
                ovf  <= 1'b0;
                unf  <= 1'b0;
            end else begin
                if (do_push)
                    wptr <= wptr + PW'(1);
                if (do_pop)
                    rptr <= rptr + PW'(1);
                case ({do_push, do_pop})
                    2'b10:   cnt <= cnt + CW'(1);
                    2'b01:   cnt <= cnt - CW'(1);
                    default: cnt <= cnt;
                endcase
                if (push[g] && is_full && !pop[g])
                    ovf <= 1'b1;
                if (pop[g] && is_empty)
                    unf <= 1'b1;
            end
        end

        always_ff @(posedge clk) begin
            if (do_push)
                mem[wptr] <= d_in[g*DATA_WIDTH +: DATA_WIDTH];
        end

        assign q_out[g*DATA_WIDTH +: DATA_WIDTH] = is_empty ? '0 : mem[rptr];
        assign empty[g]     = is_empty;
        assign full[g]      = is_full;
        assign overflow[g]  = ovf;
        assign underflow[g] = unf;
    end

endmodule

// File: tb/tb_input_queues.sv
// Directed and random checks of input_queues against a per-queue scoreboard of expected words.
module tb_input_queues;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  push = '0;
    logic [3:0]  pop = '0;
    logic [63:0] d_in = '0;
    logic [63:0] q_out;
    logic [3:0]  empty, full, overflow, underflow;

    int errors = 0;
    int checks = 0;

    logic [15:0] sb [4][$];
    logic [3:0]  m_ovf = '0;
    logic [3:0]  m_unf = '0;

    input_queues #(.DATA_WIDTH(16), .N_INPUTS(4), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .push(push), .d_in(d_in), .pop(pop),
        .q_out(q_out), .empty(empty), .full(full),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) sb[i].delete();
        m_ovf = '0;
        m_unf = '0;
    endtask

    task automatic model_edge(input logic [3:0] p, input logic [3:0] q, input logic [63:0] d);
        for (int i = 0; i < 4; i++) begin
            int n;
            n = sb[i].size();
            if (p[i] && q[i]) begin
                if (n == 0) m_unf[i] = 1'b1;
                else void'(sb[i].pop_front());
                sb[i].push_back(d[i*16 +: 16]);
            end else if (p[i]) begin
                if (n == 4) m_ovf[i] = 1'b1;
                else sb[i].push_back(d[i*16 +: 16]);
            end else if (q[i]) begin
                if (n == 0) m_unf[i] = 1'b1;
                else void'(sb[i].pop_front());
            end
        end
    endtask

    task automatic compare_all(input string tag);
        logic [63:0] eq;
        logic [3:0]  ee, ef;
        eq = '0;
        for (int i = 0; i < 4; i++) begin
            ee[i] = (sb[i].size() == 0);
            ef[i] = (sb[i].size() == 4);
            if (sb[i].size() != 0) eq[i*16 +: 16] = sb[i][0];
        end
        check({tag, "_q_out"}, q_out, eq);
        check({tag, "_empty"}, {60'd0, empty}, {60'd0, ee});
        check({tag, "_full"}, {60'd0, full}, {60'd0, ef});
        check({tag, "_overflow"}, {60'd0, overflow}, {60'd0, m_ovf});
        check({tag, "_underflow"}, {60'd0, underflow}, {60'd0, m_unf});
    endtask

    // One clock: drive, let the edge happen, advance the model, then sample 1 time unit later.
    task automatic step(input logic [3:0] p, input logic [3:0] q, input logic [63:0] d, input string tag);
        push = p;
        pop  = q;
        d_in = d;
        @(posedge clk);
        model_edge(p, q, d);
        #1;
        push = '0;
        pop  = '0;
        compare_all(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        #2;
        @(negedge clk);
        rst = 1'b1;
        #1;
    endtask

    initial begin
        do_reset();
        check("rst_q_out", q_out, 64'd0);
        check("rst_empty", {60'd0, empty}, 64'hF);
        check("rst_full", {60'd0, full}, 64'h0);
        check("rst_flags", {56'd0, overflow, underflow}, 64'h0);

        step(4'b0001, 4'b0000, 64'h0000_0000_0000_1111, "p0");
        check("r32_q0", {48'd0, q_out[15:0]}, 64'h1111);
        check("r32_empty0", {63'd0, empty[0]}, 64'd0);
        check("r32_others", {16'd0, q_out[63:16]}, 64'd0);

        for (int k = 0; k < 4; k++)
            step(4'b0100, 4'b0000, {16'd0, 16'h00A0 + 16'(k), 32'd0}, "fill2");
        step(4'b0100, 4'b0000, {16'd0, 16'h00A4, 32'd0}, "ovf2");
        check("r33_full2", {63'd0, full[2]}, 64'd1);
        check("r33_ovf2", {63'd0, overflow[2]}, 64'd1);
        for (int k = 0; k < 4; k++) begin
            check("r33_head2", {48'd0, q_out[47:32]}, 64'h00A0 + 64'(k));
            step(4'b0000, 4'b0100, 64'd0, "drain2");
        end
        check("r33_empty2", {63'd0, empty[2]}, 64'd1);

        for (int k = 0; k < 4; k++)
            step(4'b0010, 4'b0000, {32'd0, 16'h00B0 + 16'(k), 16'd0}, "fill1");
        for (int k = 0; k < 6; k++) begin
            step(4'b0010, 4'b0010, {32'd0, 16'h00B4 + 16'(k), 16'd0}, "pp1");
            check("r34_full1", {63'd0, full[1]}, 64'd1);
            check("r34_head1", {48'd0, q_out[31:16]}, 64'h00B1 + 64'(k));
        end
        check("r34_ovf1", {63'd0, overflow[1]}, 64'd0);

        step(4'b1000, 4'b1000, {16'h00C0, 48'd0}, "pp3");
        check("r35_q3", {48'd0, q_out[63:48]}, 64'h00C0);
        check("r35_unf3", {63'd0, underflow[3]}, 64'd1);
        check("r35_empty3", {63'd0, empty[3]}, 64'd0);

        do_reset();
        for (int k = 0; k < 3; k++)
            step(4'b1111, 4'b0000, {4{16'h0D00 + 16'(k)}}, "fill_all");
        step(4'b0000, 4'b0001, 64'd0, "unf_pre");
        step(4'b0000, 4'b0001, 64'd0, "unf_pre");
        step(4'b0000, 4'b0001, 64'd0, "unf_pre");
        step(4'b0000, 4'b0001, 64'd0, "unf_pre");
        check("r36_pre_unf", {63'd0, underflow[0]}, 64'd1);
        #1;
        rst = 1'b0;
        model_clear();
        #1;
        check("r36_q_out", q_out, 64'd0);
        check("r36_empty", {60'd0, empty}, 64'hF);
        check("r36_full", {60'd0, full}, 64'h0);
        check("r36_flags", {56'd0, overflow, underflow}, 64'h0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        step(4'b0010, 4'b0000, {32'd0, 16'h0E11, 16'd0}, "post_rst");
        check("r31_q1", {48'd0, q_out[31:16]}, 64'h0E11);

        for (int c = 0; c < 10000; c++) begin
            logic [3:0]  p, q;
            logic [63:0] d;
            for (int i = 0; i < 4; i++) begin
                p[i] = ($urandom_range(99) < 55);
                q[i] = ($urandom_range(99) < 45);
                d[i*16 +: 16] = 16'($urandom);
            end
            step(p, q, d, "rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
